// File: rtl/sta_sched_pkg.sv
// ---------------------------------------------------------------------------
// sta_sched_pkg
// Shared types and helpers for the STA tile scheduler slice.
//   sched_state_e   : scheduler FSM states
//   compute_cycles  : per-block MAC time, max(1, ceil(n/4))
//   DEF_*           : default array geometry and layer limits
// ---------------------------------------------------------------------------
package sta_sched_pkg;

    localparam int DEF_ROWS   = 4;
    localparam int DEF_COLS   = 4;
    localparam int DEF_NUM_CH = 64;
    localparam int DEF_MAX_N  = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Four MACs retire per cycle, so a depth-n block occupies ceil(n/4)
    // cycles; a zero depth still costs one issue slot.
    function automatic logic [15:0] compute_cycles(input logic [15:0] n);
        logic [16:0] sum;
        logic [15:0] res;
        sum = {1'b0, n} + 17'd3;
        res = {1'b0, sum[16:2]};
        if (res == 16'd0) begin
            res = 16'd1;
        end else begin
            res = res;
        end
        return res;
    endfunction

endpackage

// File: rtl/sta_tile_scheduler_if.sv
// ---------------------------------------------------------------------------
// sta_tile_scheduler_if
// Block-issue bus between the tile scheduler and the STA / output coordinator.
//   stall       : array side asks the scheduler to freeze issue
//   blk_retire  : coordinator's last PE produced a finished block
//   input_valid : inject one block at PE(0,0)
//   pos_row/pos_col/channel : block base coordinates
//   mat_size    : MAC depth of the current layer
// Modports: master = scheduler, slave = STA/coordinator.
// ---------------------------------------------------------------------------
interface sta_tile_scheduler_if
    import sta_sched_pkg::*;
#(
    parameter int N_BITS  = $clog2(DEF_MAX_N + 1),
    parameter int CH_BITS = $clog2(DEF_NUM_CH + 1)
);
    logic               stall;
    logic               blk_retire;
    logic               input_valid;
    logic [N_BITS-1:0]  pos_row;
    logic [N_BITS-1:0]  pos_col;
    logic [CH_BITS-1:0] channel;
    logic [N_BITS-1:0]  mat_size;

    modport master (
        input  stall,
        input  blk_retire,
        output input_valid,
        output pos_row,
        output pos_col,
        output channel,
        output mat_size
    );

    modport slave (
        output stall,
        output blk_retire,
        input  input_valid,
        input  pos_row,
        input  pos_col,
        input  channel,
        input  mat_size
    );
endinterface

// File: rtl/sta_tile_walker.sv
// ---------------------------------------------------------------------------
// sta_tile_walker
// Nested col/row/channel wrap counters that enumerate output blocks.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : restart walk at (0,0,0)
//   advance      : step to the next block
//   cfg_rows/cfg_cols/cfg_ch : latched layer dimensions
//   pos_row/pos_col/channel  : current block base (registered)
//   last         : current block is the final one of the layer
// ---------------------------------------------------------------------------
module sta_tile_walker
    import sta_sched_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int N_BITS  = 10,
    parameter int CH_BITS = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    input  logic [N_BITS-1:0]  cfg_rows,
    input  logic [N_BITS-1:0]  cfg_cols,
    input  logic [CH_BITS-1:0] cfg_ch,
    output logic [N_BITS-1:0]  pos_row,
    output logic [N_BITS-1:0]  pos_col,
    output logic [CH_BITS-1:0] channel,
    output logic               last
);
    logic [N_BITS:0] col_sum_s;
    logic [N_BITS:0] row_sum_s;
    logic            col_wrap_s;
    logic            row_wrap_s;
    logic            ch_last_s;

    // Wrap tests use one extra bit so base+step cannot overflow; partial
    // edge blocks still issue because the test is on the next base.
    always_comb begin
        col_sum_s  = {1'b0, pos_col} + (N_BITS + 1)'(COLS);
        row_sum_s  = {1'b0, pos_row} + (N_BITS + 1)'(ROWS);
        col_wrap_s = (col_sum_s >= {1'b0, cfg_cols});
        row_wrap_s = (row_sum_s >= {1'b0, cfg_rows});
        ch_last_s  = (channel == (cfg_ch - CH_BITS'(1)));
        last       = col_wrap_s && row_wrap_s && ch_last_s;
    end

    // Counter registers: col innermost, then row, then channel.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pos_row <= {N_BITS{1'b0}};
            pos_col <= {N_BITS{1'b0}};
            channel <= {CH_BITS{1'b0}};
        end else if (advance) begin
            if (col_wrap_s) begin
                pos_col <= {N_BITS{1'b0}};
                if (row_wrap_s) begin
                    pos_row <= {N_BITS{1'b0}};
                    channel <= channel + CH_BITS'(1);
                end else begin
                    pos_row <= row_sum_s[N_BITS-1:0];
                end
            end else begin
                pos_col <= col_sum_s[N_BITS-1:0];
            end
        end else begin
            pos_row <= pos_row;
            pos_col <= pos_col;
            channel <= channel;
        end
    end

endmodule

// File: rtl/sta_tile_scheduler.sv
// ---------------------------------------------------------------------------
// sta_tile_scheduler
// Walks one layer's output map and issues ROWS x COLS blocks to the STA,
// spacing issues by the per-block MAC time and counting block retirements
// until every issued block has drained.
//   clk, reset            : clock, synchronous active-high reset
//   start, cfg_*          : layer launch and configuration (IDLE only)
//   sta (master modport)  : stall/blk_retire in; input_valid, block coords,
//                           mat_size out
//   busy, done            : layer in progress / one-cycle end pulse
//   perf_cycles/perf_stalls : busy and stall counters
// Optional feature macro: STA_SCHED_PERF_EN enables the perf counters;
// without it both perf outputs are constant zero.
// ---------------------------------------------------------------------------
module sta_tile_scheduler
    import sta_sched_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CH_BITS  = $clog2(NUM_CH + 1),
    parameter int MAX_N    = DEF_MAX_N,
    parameter int N_BITS   = $clog2(MAX_N + 1),
    parameter int OUT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [N_BITS-1:0]   cfg_mat_size,
    input  logic [N_BITS-1:0]   cfg_out_rows,
    input  logic [N_BITS-1:0]   cfg_out_cols,
    input  logic [CH_BITS-1:0]  cfg_num_ch,
    sta_tile_scheduler_if.master sta,
    output logic                busy,
    output logic                done,
    output logic [31:0]         perf_cycles,
    output logic [31:0]         perf_stalls
);
    sched_state_e        state_r;
    sched_state_e        next_state_s;
    logic [N_BITS-1:0]   rows_r;
    logic [N_BITS-1:0]   cols_r;
    logic [CH_BITS-1:0]  ch_r;
    logic [N_BITS-1:0]   mat_size_r;
    logic [N_BITS-1:0]   cc_r;
    logic [N_BITS-1:0]   gap_r;
    logic [OUT_BITS-1:0] out_r;
    logic [OUT_BITS-1:0] out_next_s;
    logic                issue_s;
    logic                retire_s;
    logic                start_ok_s;
    logic                cfg_zero_s;
    logic                last_s;
    logic                busy_s;
    logic [N_BITS-1:0]   cc_load_s;

    // Control decodes shared by the FSM and the datapath.
    always_comb begin
        busy_s     = (state_r != ST_IDLE);
        issue_s    = (state_r == ST_ISSUE) && !sta.stall;
        retire_s   = sta.blk_retire && busy_s;
        start_ok_s = (state_r == ST_IDLE) && start;
        cfg_zero_s = (cfg_out_rows == {N_BITS{1'b0}}) ||
                     (cfg_out_cols == {N_BITS{1'b0}}) ||
                     (cfg_num_ch == {CH_BITS{1'b0}});
        cc_load_s  = N_BITS'(compute_cycles(16'(cfg_mat_size)));
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = cfg_zero_s ? ST_DONE : ST_ISSUE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!issue_s) begin
                    next_state_s = ST_ISSUE;
                end else if (last_s) begin
                    next_state_s = ST_DRAIN;
                end else if (cc_r == N_BITS'(1)) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_GAP: begin
                // Leaving on the decrement to zero makes issues exactly
                // compute_cycles apart.
                if (sta.stall) begin
                    next_state_s = ST_GAP;
                end else if (gap_r <= N_BITS'(1)) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_DRAIN: begin
                if ((out_r == {OUT_BITS{1'b0}}) && !sta.blk_retire) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Outstanding-block count: issue and retire in one cycle cancel, a
    // retire with nothing outstanding is dropped, and the count saturates.
    always_comb begin
        out_next_s = out_r;
        if (issue_s && !retire_s) begin
            if (out_r == {OUT_BITS{1'b1}}) begin
                out_next_s = out_r;
            end else begin
                out_next_s = out_r + OUT_BITS'(1);
            end
        end else if (!issue_s && retire_s && (out_r != {OUT_BITS{1'b0}})) begin
            out_next_s = out_r - OUT_BITS'(1);
        end else begin
            out_next_s = out_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Layer configuration latched on an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_r     <= {N_BITS{1'b0}};
            cols_r     <= {N_BITS{1'b0}};
            ch_r       <= {CH_BITS{1'b0}};
            mat_size_r <= {N_BITS{1'b0}};
            cc_r       <= N_BITS'(1);
        end else if (start_ok_s) begin
            rows_r     <= cfg_out_rows;
            cols_r     <= cfg_out_cols;
            ch_r       <= cfg_num_ch;
            mat_size_r <= cfg_mat_size;
            cc_r       <= cc_load_s;
        end else begin
            rows_r     <= rows_r;
            cols_r     <= cols_r;
            ch_r       <= ch_r;
            mat_size_r <= mat_size_r;
            cc_r       <= cc_r;
        end
    end

    // Inter-issue gap counter; frozen while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_r <= {N_BITS{1'b0}};
        end else if (issue_s) begin
            gap_r <= cc_r - N_BITS'(1);
        end else if ((state_r == ST_GAP) && !sta.stall && (gap_r != {N_BITS{1'b0}})) begin
            gap_r <= gap_r - N_BITS'(1);
        end else begin
            gap_r <= gap_r;
        end
    end

    // Outstanding-block register.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            out_r <= {OUT_BITS{1'b0}};
        end else begin
            out_r <= out_next_s;
        end
    end

    // The final block does not advance the walker, so the coordinate
    // outputs keep showing the last block issued.
    sta_tile_walker #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .N_BITS  (N_BITS),
        .CH_BITS (CH_BITS)
    ) u_walker (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok_s),
        .advance  (issue_s && !last_s),
        .cfg_rows (rows_r),
        .cfg_cols (cols_r),
        .cfg_ch   (ch_r),
        .pos_row  (sta.pos_row),
        .pos_col  (sta.pos_col),
        .channel  (sta.channel),
        .last     (last_s)
    );

    assign sta.input_valid = issue_s;
    assign sta.mat_size    = mat_size_r;
    assign busy            = busy_s;
    assign done            = (state_r == ST_DONE);

`ifdef STA_SCHED_PERF_EN
    logic [31:0] perf_cycles_r;
    logic [31:0] perf_stalls_r;

    // Saturating busy-cycle and issue-stall counters, cleared per layer.
    always_ff @(posedge clk) begin
        if (reset || start_ok_s) begin
            perf_cycles_r <= 32'd0;
            perf_stalls_r <= 32'd0;
        end else begin
            if (busy_s && (perf_cycles_r != 32'hFFFF_FFFF)) begin
                perf_cycles_r <= perf_cycles_r + 32'd1;
            end else begin
                perf_cycles_r <= perf_cycles_r;
            end
            if (sta.stall && ((state_r == ST_ISSUE) || (state_r == ST_GAP)) &&
                (perf_stalls_r != 32'hFFFF_FFFF)) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end else begin
                perf_stalls_r <= perf_stalls_r;
            end
        end
    end

    assign perf_cycles = perf_cycles_r;
    assign perf_stalls = perf_stalls_r;
`else
    assign perf_cycles = 32'd0;
    assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sta_tile_scheduler
// Directed bench for sta_tile_scheduler (ROWS=COLS=4). Cycle 0 of each
// scenario is the start cycle; inputs change 1 time unit after the rising
// edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sta_tile_scheduler;
    import sta_sched_pkg::*;

    localparam int N_BITS  = 10;
    localparam int CH_BITS = 7;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [N_BITS-1:0]  cfg_mat_size;
    logic [N_BITS-1:0]  cfg_out_rows;
    logic [N_BITS-1:0]  cfg_out_cols;
    logic [CH_BITS-1:0] cfg_num_ch;
    logic               busy;
    logic               done;
    logic [31:0]        perf_cycles;
    logic [31:0]        perf_stalls;

    int n_checks = 0;
    int n_fail   = 0;

    sta_tile_scheduler_if #(.N_BITS(N_BITS), .CH_BITS(CH_BITS)) sta_bus ();

    sta_tile_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_mat_size (cfg_mat_size),
        .cfg_out_rows (cfg_out_rows),
        .cfg_out_cols (cfg_out_cols),
        .cfg_num_ch   (cfg_num_ch),
        .sta          (sta_bus),
        .busy         (busy),
        .done         (done),
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls)
    );

    always #5 clk = ~clk;

    // Drive one start cycle (cycle 0) and move to cycle 1.
    task automatic begin_layer(input logic [N_BITS-1:0] m, input logic [N_BITS-1:0] r,
                               input logic [N_BITS-1:0] c, input logic [CH_BITS-1:0] ch);
        cfg_mat_size = m;
        cfg_out_rows = r;
        cfg_out_cols = c;
        cfg_num_ch   = ch;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (sta_bus.input_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sta_bus.input_valid); end
        n_checks++; if (sta_bus.pos_row !== 10'd0) begin n_fail++; $display("FAIL reset_row: got %0d want 0", sta_bus.pos_row); end
        n_checks++; if (sta_bus.pos_col !== 10'd0) begin n_fail++; $display("FAIL reset_col: got %0d want 0", sta_bus.pos_col); end
        n_checks++; if (sta_bus.channel !== 7'd0) begin n_fail++; $display("FAIL reset_ch: got %0d want 0", sta_bus.channel); end
        n_checks++; if (sta_bus.mat_size !== 10'd0) begin n_fail++; $display("FAIL reset_mat: got %0d want 0", sta_bus.mat_size); end
        n_checks++; if (perf_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_perf_cycles: got %0d want 0", perf_cycles); end
        n_checks++; if (perf_stalls !== 32'd0) begin n_fail++; $display("FAIL reset_perf_stalls: got %0d want 0", perf_stalls); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // 8x8 map, 2 ch, depth 9: issues every 3 cycles from cycle 1 to 22.
    task automatic test_basic();
        logic [N_BITS-1:0]  exp_r [8];
        logic [N_BITS-1:0]  exp_c [8];
        logic [CH_BITS-1:0] exp_h [8];
        logic exp_v;
        int   pulses = 0;
        logic [31:0] exp_pc;
        logic [31:0] exp_ps;
        for (int i = 0; i < 8; i++) begin
            exp_c[i] = ((i % 2) == 1) ? 10'd4 : 10'd0;
            exp_r[i] = (((i / 2) % 2) == 1) ? 10'd4 : 10'd0;
            exp_h[i] = (i >= 4) ? 7'd1 : 7'd0;
        end
        begin_layer(10'd9, 10'd8, 10'd8, 7'd2);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            sta_bus.blk_retire = (cyc >= 5) && (cyc <= 26) && (((cyc - 5) % 3) == 0);
            @(negedge clk);
            exp_v = (cyc <= 22) && (((cyc - 1) % 3) == 0);
            n_checks++; if (sta_bus.input_valid !== exp_v) begin n_fail++; $display("FAIL basic_valid@%0d: got %b want %b", cyc, sta_bus.input_valid, exp_v); end
            if (sta_bus.input_valid === 1'b1 && pulses < 8) begin
                n_checks++;
                if (sta_bus.pos_row !== exp_r[pulses] || sta_bus.pos_col !== exp_c[pulses] ||
                    sta_bus.channel !== exp_h[pulses] || sta_bus.mat_size !== 10'd9) begin
                    n_fail++;
                    $display("FAIL basic_coord#%0d: got (%0d,%0d,%0d,m%0d) want (%0d,%0d,%0d,m9)", pulses,
                             sta_bus.pos_row, sta_bus.pos_col, sta_bus.channel, sta_bus.mat_size,
                             exp_r[pulses], exp_c[pulses], exp_h[pulses]);
                end
                pulses++;
            end
            n_checks++; if (done !== (cyc == 28)) begin n_fail++; $display("FAIL basic_done@%0d: got %b want %b", cyc, done, (cyc == 28)); end
            if (cyc == 29) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after_done: got %b want 0", busy); end
            end
            @(posedge clk); #1;
        end
        sta_bus.blk_retire = 1'b0;
        n_checks++; if (pulses != 8) begin n_fail++; $display("FAIL basic_pulse_count: got %0d want 8", pulses); end
`ifdef STA_SCHED_PERF_EN
        exp_pc = 32'd28;
        exp_ps = 32'd0;
`else
        exp_pc = 32'd0;
        exp_ps = 32'd0;
`endif
        n_checks++; if (perf_cycles !== exp_pc) begin n_fail++; $display("FAIL basic_perf_cycles: got %0d want %0d", perf_cycles, exp_pc); end
        n_checks++; if (perf_stalls !== exp_ps) begin n_fail++; $display("FAIL basic_perf_stalls: got %0d want %0d", perf_stalls, exp_ps); end
    endtask

    // Depth 3 (one cycle per block), 4x8 map: pulses at cycles 1 and 2.
    task automatic test_back_to_back();
        logic exp_v;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc == 1) begin
                cyc = 1;
            end
        end
        begin_layer(10'd3, 10'd4, 10'd8, 7'd1);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            sta_bus.blk_retire = (cyc == 4) || (cyc == 5);
            @(negedge clk);
            exp_v = (cyc == 1) || (cyc == 2);
            n_checks++; if (sta_bus.input_valid !== exp_v) begin n_fail++; $display("FAIL b2b_valid@%0d: got %b want %b", cyc, sta_bus.input_valid, exp_v); end
            if (cyc <= 2) begin
                n_checks++;
                if (sta_bus.pos_col !== ((cyc == 2) ? 10'd4 : 10'd0) || sta_bus.pos_row !== 10'd0) begin
                    n_fail++; $display("FAIL b2b_coord@%0d: got (%0d,%0d) want (0,%0d)", cyc, sta_bus.pos_row, sta_bus.pos_col, (cyc == 2) ? 4 : 0);
                end
            end
            n_checks++; if (done !== (cyc == 7)) begin n_fail++; $display("FAIL b2b_done@%0d: got %b want %b", cyc, done, (cyc == 7)); end
            @(posedge clk); #1;
        end
        sta_bus.blk_retire = 1'b0;
    endtask

    // 6x6 map: four blocks incl. partial edges, depth 4 -> back-to-back.
    task automatic test_partial();
        logic [N_BITS-1:0] exp_r [4];
        logic [N_BITS-1:0] exp_c [4];
        exp_r[0] = 10'd0; exp_c[0] = 10'd0;
        exp_r[1] = 10'd0; exp_c[1] = 10'd4;
        exp_r[2] = 10'd4; exp_c[2] = 10'd0;
        exp_r[3] = 10'd4; exp_c[3] = 10'd4;
        begin_layer(10'd4, 10'd6, 10'd6, 7'd1);
        for (int cyc = 1; cyc <= 13; cyc++) begin
            sta_bus.blk_retire = (cyc >= 6) && (cyc <= 9);
            @(negedge clk);
            n_checks++; if (sta_bus.input_valid !== (cyc <= 4)) begin n_fail++; $display("FAIL partial_valid@%0d: got %b want %b", cyc, sta_bus.input_valid, (cyc <= 4)); end
            if (cyc <= 4) begin
                n_checks++;
                if (sta_bus.pos_row !== exp_r[cyc-1] || sta_bus.pos_col !== exp_c[cyc-1]) begin
                    n_fail++; $display("FAIL partial_coord@%0d: got (%0d,%0d) want (%0d,%0d)", cyc, sta_bus.pos_row, sta_bus.pos_col, exp_r[cyc-1], exp_c[cyc-1]);
                end
            end
            n_checks++; if (done !== (cyc == 11)) begin n_fail++; $display("FAIL partial_done@%0d: got %b want %b", cyc, done, (cyc == 11)); end
            @(posedge clk); #1;
        end
        sta_bus.blk_retire = 1'b0;
    endtask

    // Stall held 5 cycles in GAP: second issue moves from cycle 4 to 9.
    task automatic test_stall();
        logic [31:0] exp_ps;
        begin_layer(10'd9, 10'd4, 10'd8, 7'd1);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            sta_bus.stall      = (cyc >= 2) && (cyc <= 6);
            sta_bus.blk_retire = (cyc == 5) || (cyc == 11);
            @(negedge clk);
            n_checks++; if (sta_bus.input_valid !== ((cyc == 1) || (cyc == 9))) begin n_fail++; $display("FAIL stall_valid@%0d: got %b want %b", cyc, sta_bus.input_valid, ((cyc == 1) || (cyc == 9))); end
            if (cyc == 9) begin
                n_checks++; if (sta_bus.pos_col !== 10'd4) begin n_fail++; $display("FAIL stall_coord: got col %0d want 4", sta_bus.pos_col); end
            end
            n_checks++; if (done !== (cyc == 13)) begin n_fail++; $display("FAIL stall_done@%0d: got %b want %b", cyc, done, (cyc == 13)); end
            @(posedge clk); #1;
        end
        sta_bus.stall      = 1'b0;
        sta_bus.blk_retire = 1'b0;
`ifdef STA_SCHED_PERF_EN
        exp_ps = 32'd5;
`else
        exp_ps = 32'd0;
`endif
        n_checks++; if (perf_stalls !== exp_ps) begin n_fail++; $display("FAIL stall_perf_stalls: got %0d want %0d", perf_stalls, exp_ps); end
    endtask

    // Zero channels: done at cycle 1, no issue, idle at cycle 2.
    task automatic test_zero_ch();
        begin_layer(10'd9, 10'd8, 10'd8, 7'd0);
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b want 1", done); end
        n_checks++; if (sta_bus.input_valid !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %b want 0", sta_bus.input_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy1: got %b want 1", busy); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done2: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy2: got %b want 0", busy); end
        @(posedge clk); #1;
    endtask

    // A second start mid-layer (zero channels, depth 3) must be ignored.
    task automatic test_start_while_busy();
        begin_layer(10'd9, 10'd4, 10'd8, 7'd1);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc == 2) begin
                cfg_num_ch   = 7'd0;
                cfg_mat_size = 10'd3;
                start        = 1'b1;
            end else begin
                start        = 1'b0;
            end
            sta_bus.blk_retire = (cyc == 5) || (cyc == 6);
            @(negedge clk);
            n_checks++; if (sta_bus.input_valid !== ((cyc == 1) || (cyc == 4))) begin n_fail++; $display("FAIL sbusy_valid@%0d: got %b want %b", cyc, sta_bus.input_valid, ((cyc == 1) || (cyc == 4))); end
            if (cyc == 4) begin
                n_checks++;
                if (sta_bus.pos_col !== 10'd4 || sta_bus.mat_size !== 10'd9) begin
                    n_fail++; $display("FAIL sbusy_coord: got col %0d mat %0d want col 4 mat 9", sta_bus.pos_col, sta_bus.mat_size);
                end
            end
            n_checks++; if (done !== (cyc == 8)) begin n_fail++; $display("FAIL sbusy_done@%0d: got %b want %b", cyc, done, (cyc == 8)); end
            @(posedge clk); #1;
        end
        start              = 1'b0;
        sta_bus.blk_retire = 1'b0;
    endtask

    // Reset during GAP aborts: idle next cycle and no done afterwards.
    task automatic test_reset_mid();
        begin_layer(10'd9, 10'd8, 10'd8, 7'd2);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            reset = (cyc == 2);
            @(negedge clk);
            if (cyc == 2) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_gap: got %b want 1", busy); end
            end
            if (cyc >= 3) begin
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy@%0d: got %b want 0", cyc, busy); end
                n_checks++; if (done !== 1'b0 || sta_bus.input_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_quiet@%0d: got done %b valid %b want 0 0", cyc, done, sta_bus.input_valid); end
            end
            if (cyc == 3) begin
                n_checks++; if (sta_bus.pos_col !== 10'd0 || sta_bus.mat_size !== 10'd0) begin n_fail++; $display("FAIL rmid_zero: got col %0d mat %0d want 0 0", sta_bus.pos_col, sta_bus.mat_size); end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        cfg_mat_size       = 10'd0;
        cfg_out_rows       = 10'd0;
        cfg_out_cols       = 10'd0;
        cfg_num_ch         = 7'd0;
        sta_bus.stall      = 1'b0;
        sta_bus.blk_retire = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_partial();
        test_stall();
        test_zero_ch();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
